grid_io_bank: RTL and testbench
===============================

Name: grid_io_bank

Overview:
- Parametrised successor to the single-pad IO grid tile: one tile serving NUM_IO GPIO pads.
- Per-pad direction and input-enable come from a configuration-chain (ccff) segment.
- Config is double-buffered: the shift register is a shadow copy, and a qualified load commits it to the active config, so pads never glitch during reprogramming.
- Sits on the FPGA perimeter, stitched into the global ccff chain via ccff_head/ccff_tail.

Parameters:
- NUM_IO, 4, number of pads/subtiles in the bank.
- CFG_W, 2, config bits per pad: bit0 = DIR (1 = drive pad), bit1 = IE (1 = pass pad to fabric).
- CHAIN_LEN, NUM_IO*CFG_W, derived (localparam); shadow chain length excluding the optional parity bit.
- CNT_W, $clog2(CHAIN_LEN+2), derived; shift-counter width.

Ports:
- prog_clk  input  1  configuration/tile clock; all flops rising-edge.
- prog_reset_n  input  1  asynchronous active-low reset.
- cfg_en  input  1  shift enable; one chain bit per cycle while high.
- cfg_load  input  1  single-cycle request to commit shadow to active config.
- ccff_head  input  1  serial config in.
- ccff_tail  output  1  serial config out (last shadow bit).
- gfpga_pad_GPIO_PAD  inout  NUM_IO  bidirectional pads.
- io_outpad  input  NUM_IO  fabric data to drive onto pads.
- io_inpad  output  NUM_IO  pad data to fabric.
- cfg_done  output  1  shadow holds exactly one full chain since last load/reset.
- cfg_err  output  1  sticky: last load request rejected.
- cfg_active  output  1  at least one successful load since reset.

Behaviour:
- Reset (async, prog_reset_n=0):
  - shadow, active config, counter, cfg_err and cfg_active all clear to 0.
  - ccff_tail=0, io_inpad=0, all pads hi-Z.
  - Takes effect mid-shift or mid-load without waiting for a clock.
- Shift (cfg_en=1):
  - shadow <= {shadow[LEN-2:0], ccff_head}, with shadow[0] taking ccff_head.
  - ccff_tail = shadow[LEN-1], registered, one bit per cycle.
  - The first bit shifted in ends at the MSB.
  - Pad i config = shadow[i*CFG_W +: CFG_W].
- Counter:
  - Increments on each shift; saturates at LEN+1 (overshift flag).
  - cfg_done = (count == LEN), combinational from the counter.
- States:
  - EMPTY: count=0.
  - FILLING: 0<count<LEN.
  - FULL: count=LEN.
  - OVER: count>LEN.
  - Shifting moves EMPTY→FILLING→FULL→OVER.
  - A load from any state returns to EMPTY.
- Load (cfg_load=1, cfg_en=0):
  - In FULL (and parity OK when enabled): active <= shadow[CHAIN_LEN-1:0]; cfg_err<=0; cfg_active<=1; count<=0.
  - Otherwise: active unchanged, cfg_err<=1, count<=0.
  - New active config is visible on pads the cycle after the load edge.
- cfg_load and cfg_en high in the same cycle: shift happens, load is rejected (cfg_err<=1), count is not cleared.
- Pad path (combinational from active config):
  - pad[i] = DIR_i ? io_outpad[i] : 1'bz.
  - io_inpad[i] = IE_i & pad[i].
  - DIR=1 with IE=1 is legal loopback.
- Shadow contents persist after load; ccff_tail continues to reflect shadow MSB.

Optional Feature:
- Macro: GRID_IO_BANK_PARITY_EN.
- Defined:
  - Shadow length is CHAIN_LEN+1; the extra bit sits at the MSB (the first bit shifted).
  - FULL means count==CHAIN_LEN+1.
  - Load additionally requires XOR of all shadow bits == 1 (odd parity); a mismatch sets cfg_err and leaves active unchanged.
  - ccff_tail comes from the parity position.
- Undefined: LEN=CHAIN_LEN, no parity check.

Decomposition:
- Shared package grid_io_pkg:
  - Constants CFG_DIR_BIT=0 and CFG_IE_BIT=1.
  - Fill-state encoding (EMPTY/FILLING/FULL/OVER).
  - Parity function.
- One natural sub-module: grid_io_pad_cell.
  - Per-pad tristate driver plus IE gating, instantiated NUM_IO times via generate.
  - All sequential logic stays in the top.

Test Plan:
- Reset: assert prog_reset_n=0 mid-shift → all outputs 0, pads hi-Z, count 0 immediately without clock; deassert → still hi-Z.
- Full load (NUM_IO=4): shift 8'h1E MSB-first (8 cycles), pulse cfg_load; io_outpad=4'b0110, external drive pad0=1 → pads[2:1] driven 1,1; pad3 hi-Z; io_inpad=4'b0011 (pad0 input, pad1 loopback).
- Short load: shift 5 bits then cfg_load → cfg_err=1, pads keep the previous config; a following correct 8-bit shift plus load → cfg_err=0.
- Overshift: shift 9 bits then cfg_load → rejected, cfg_err=1; ccff_tail outputs the first-shifted bit on the 9th cycle.
- Simultaneous events: cfg_en=1 and cfg_load=1 in the same cycle at count=8 → shift occurs, count=9, cfg_err=1, active unchanged.
- With GRID_IO_BANK_PARITY_EN: shift 9'b1_0001_1110 (parity bit first) → load accepted; flip one data bit → cfg_err=1, active unchanged.

Source files
------------

// File: rtl/grid_io_pkg.sv
// Shared constants, fill-state encoding and parity helper for grid_io_bank.
// Parity width is fixed at PAR_MAX_W; callers zero-extend their vectors.
package grid_io_pkg;

    localparam int CFG_DIR_BIT = 0;
    localparam int CFG_IE_BIT  = 1;
    localparam int PAR_MAX_W   = 64;

    typedef enum logic [1:0] {
        FILL_EMPTY,
        FILL_FILLING,
        FILL_FULL,
        FILL_OVER
    } fill_state_t;

    function automatic logic odd_parity(
        input logic [PAR_MAX_W-1:0] v
    );
        return ^v;
    endfunction

endpackage

// File: rtl/grid_io_pad_cell.sv
// One GPIO pad: tristate driver from DIR and input gating from IE.
// Purely combinational; the config bits come from the active register.
module grid_io_pad_cell (
    input  logic dir,
    input  logic ie,
    input  logic outpad,
    inout  wire  pad,
    output logic inpad
);

    assign pad   = dir ? outpad : 1'bz;
    assign inpad = ie & pad;

endmodule

// File: rtl/grid_io_bank.sv
// NUM_IO-pad perimeter IO bank with a double-buffered ccff config segment.
// Define GRID_IO_BANK_PARITY_EN to add an odd-parity bit at the chain MSB.
module grid_io_bank
    import grid_io_pkg::*;
#(
    parameter int NUM_IO = 4,
    parameter int CFG_W  = 2
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              cfg_en,
    input  logic              cfg_load,
    input  logic              ccff_head,
    output logic              ccff_tail,
    inout  wire  [NUM_IO-1:0] gfpga_pad_GPIO_PAD,
    input  logic [NUM_IO-1:0] io_outpad,
    output logic [NUM_IO-1:0] io_inpad,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              cfg_active
);

    localparam int CHAIN_LEN = NUM_IO * CFG_W;
`ifdef GRID_IO_BANK_PARITY_EN
    localparam int LEN = CHAIN_LEN + 1;
`else
    localparam int LEN = CHAIN_LEN;
`endif
    localparam int CNT_W = $clog2(LEN + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LEN);

    logic [LEN-1:0]       shadow_q, shadow_d;
    logic [CHAIN_LEN-1:0] active_q, active_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 err_q, err_d;
    logic                 on_q, on_d;
    logic                 par_ok;
    fill_state_t          fill;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            shadow_q <= '0;
            active_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            on_q     <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            count_q  <= count_d;
            err_q    <= err_d;
            on_q     <= on_d;
        end
    end

    always_comb begin
        fill = FILL_EMPTY;
        if (count_q > CNT_FULL)
            fill = FILL_OVER;
        else if (count_q == CNT_FULL)
            fill = FILL_FULL;
        else if (count_q != '0)
            fill = FILL_FILLING;
    end

`ifdef GRID_IO_BANK_PARITY_EN
    assign par_ok = odd_parity(PAR_MAX_W'(shadow_q));
`else
    assign par_ok = 1'b1;
`endif

    // A shift always wins; a load seen alongside it is simply rejected.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        count_d  = count_q;
        err_d    = err_q;
        on_d     = on_q;
        priority case (1'b1)
            cfg_en: begin
                shadow_d = {shadow_q[LEN-2:0], ccff_head};
                if (fill != FILL_OVER)
                    count_d = count_q + 1'b1;
                if (cfg_load)
                    err_d = 1'b1;
            end
            cfg_load: begin
                count_d = '0;
                if (fill == FILL_FULL && par_ok) begin
                    active_d = shadow_q[CHAIN_LEN-1:0];
                    err_d    = 1'b0;
                    on_d     = 1'b1;
                end else begin
                    err_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ccff_tail  = shadow_q[LEN-1];
    assign cfg_done   = (count_q == CNT_FULL);
    assign cfg_err    = err_q;
    assign cfg_active = on_q;

    for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
        grid_io_pad_cell u_cell (
            .dir    (active_q[i*CFG_W+CFG_DIR_BIT]),
            .ie     (active_q[i*CFG_W+CFG_IE_BIT]),
            .outpad (io_outpad[i]),
            .pad    (gfpga_pad_GPIO_PAD[i]),
            .inpad  (io_inpad[i])
        );
    end

endmodule

// File: tb/tb_grid_io_bank.sv
// Scoreboard bench for grid_io_bank: a behavioural model predicts every
// cycle's outputs; expectations are queued with stimulus and compared later.
module tb_grid_io_bank;

    localparam int NUM_IO    = 4;
    localparam int CHAIN_LEN = 8;
`ifdef GRID_IO_BANK_PARITY_EN
    localparam int LEN = CHAIN_LEN + 1;
`else
    localparam int LEN = CHAIN_LEN;
`endif

    typedef struct packed {
        logic       tail;
        logic       done;
        logic       err;
        logic       on;
        logic [3:0] inpad;
        logic [3:0] pads;
    } obs_t;

    logic       prog_clk = 1'b0;
    logic       prog_reset_n;
    logic       cfg_en;
    logic       cfg_load;
    logic       ccff_head;
    logic       ccff_tail;
    wire  [3:0] pads;
    logic [3:0] io_outpad;
    logic [3:0] io_inpad;
    logic       cfg_done;
    logic       cfg_err;
    logic       cfg_active;

    logic [3:0] ext_val;
    logic [3:0] ext_en;

    logic [LEN-1:0]       m_sh;
    logic [CHAIN_LEN-1:0] m_cfg;
    int                   m_cnt;
    logic                 m_err;
    logic                 m_on;

    obs_t expq[$];
    obs_t gotq[$];
    obs_t e, g;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 prog_clk = ~prog_clk;

    for (genvar i = 0; i < NUM_IO; i++) begin : g_ext
        assign ext_en[i] = ~m_cfg[i*2];
        assign pads[i]   = ext_en[i] ? ext_val[i] : 1'bz;
    end

    grid_io_bank #(.NUM_IO(NUM_IO), .CFG_W(2)) dut (
        .prog_clk           (prog_clk),
        .prog_reset_n       (prog_reset_n),
        .cfg_en             (cfg_en),
        .cfg_load           (cfg_load),
        .ccff_head          (ccff_head),
        .ccff_tail          (ccff_tail),
        .gfpga_pad_GPIO_PAD (pads),
        .io_outpad          (io_outpad),
        .io_inpad           (io_inpad),
        .cfg_done           (cfg_done),
        .cfg_err            (cfg_err),
        .cfg_active         (cfg_active)
    );

    function automatic obs_t model_obs();
        obs_t o;
        for (int i = 0; i < NUM_IO; i++)
            o.pads[i] = m_cfg[i*2] ? io_outpad[i] : ext_val[i];
        for (int i = 0; i < NUM_IO; i++)
            o.inpad[i] = m_cfg[i*2+1] & o.pads[i];
        o.tail = m_sh[LEN-1];
        o.done = (m_cnt == LEN);
        o.err  = m_err;
        o.on   = m_on;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.tail  = ccff_tail;
        o.done  = cfg_done;
        o.err   = cfg_err;
        o.on    = cfg_active;
        o.inpad = io_inpad;
        o.pads  = pads;
        return o;
    endfunction

    task automatic model_reset();
        m_sh  = '0;
        m_cfg = '0;
        m_cnt = 0;
        m_err = 1'b0;
        m_on  = 1'b0;
    endtask

    task automatic record();
        expq.push_back(model_obs());
        gotq.push_back(sample());
    endtask

    task automatic step(input logic en, input logic ld, input logic hd);
        logic ok;
        cfg_en    = en;
        cfg_load  = ld;
        ccff_head = hd;
        @(posedge prog_clk);
`ifdef GRID_IO_BANK_PARITY_EN
        ok = (^m_sh) == 1'b1;
`else
        ok = 1'b1;
`endif
        if (en) begin
            if (ld) m_err = 1'b1;
            m_sh = {m_sh[LEN-2:0], hd};
            if (m_cnt < LEN + 1) m_cnt++;
        end else if (ld) begin
            if (m_cnt == LEN && ok) begin
                m_cfg = m_sh[CHAIN_LEN-1:0];
                m_err = 1'b0;
                m_on  = 1'b1;
            end else begin
                m_err = 1'b1;
            end
            m_cnt = 0;
        end
        #1;
        cfg_en   = 1'b0;
        cfg_load = 1'b0;
        record();
    endtask

    task automatic shift_cfg(input logic [7:0] w);
`ifdef GRID_IO_BANK_PARITY_EN
        step(1'b1, 1'b0, ~^w);
`endif
        for (int b = 7; b >= 0; b--)
            step(1'b1, 1'b0, w[b]);
    endtask

    task automatic test_reset();
        io_outpad = 4'b1111;
        ext_val   = 4'b0000;
        #2;
        record();
        @(posedge prog_clk);
        #1;
        prog_reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        cfg_en    = 1'b1;
        ccff_head = 1'b1;
        #2;
        prog_reset_n = 1'b0;
        model_reset();
        #1;
        record();
        if ({ccff_tail, cfg_done, cfg_err, cfg_active, io_inpad} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: got %b exp 00000000",
                     {ccff_tail, cfg_done, cfg_err, cfg_active, io_inpad});
        end
        vectors++;
        cfg_en = 1'b0;
        prog_reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            g = gotq.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL reset: got %b exp %b", g, e);
            end
        end
    endtask

    task automatic test_full_load();
        io_outpad = 4'b0110;
        ext_val   = 4'b0001;
        shift_cfg(8'h1E);
        step(1'b0, 1'b1, 1'b0);
`ifndef GRID_IO_BANK_PARITY_EN
        vectors++;
        if (io_inpad !== 4'b0011 || pads[2:1] !== 2'b11) begin
            miscompares++;
            $display("FAIL full_load_pins: inpad %b pads %b exp 0011 / x11x",
                     io_inpad, pads);
        end
`endif
        io_outpad = 4'b1111;
        ext_val   = 4'b0000;
        #1;
        record();
        while (expq.size() > 0) begin
            e = expq.pop_front();
            g = gotq.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL full_load: got %b exp %b", g, e);
            end
        end
    endtask

    task automatic test_short_load();
        io_outpad = 4'b1010;
        ext_val   = 4'b0101;
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, i[0]);
        step(1'b0, 1'b1, 1'b0);
        vectors++;
        if (cfg_err !== 1'b1) begin
            miscompares++;
            $display("FAIL short_err: got %b exp 1", cfg_err);
        end
        shift_cfg(8'hA5);
        step(1'b0, 1'b1, 1'b0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            g = gotq.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL short_load: got %b exp %b", g, e);
            end
        end
    endtask

    task automatic test_overshift();
        io_outpad = 4'b1100;
        ext_val   = 4'b0011;
        for (int i = 0; i < LEN + 1; i++) begin
            step(1'b1, 1'b0, (i == 0));
            if (i == LEN - 1) begin
                vectors++;
                if (ccff_tail !== 1'b1) begin
                    miscompares++;
                    $display("FAIL over_tail: got %b exp 1", ccff_tail);
                end
            end
        end
        step(1'b0, 1'b1, 1'b0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            g = gotq.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL overshift: got %b exp %b", g, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        io_outpad = 4'b0101;
        ext_val   = 4'b1010;
        shift_cfg(8'h3C);
        step(1'b1, 1'b1, 1'b1);
        vectors++;
        if (cfg_err !== 1'b1 || cfg_done !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_flags: err %b done %b exp 1 0", cfg_err, cfg_done);
        end
        step(1'b0, 1'b1, 1'b0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            g = gotq.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL simultaneous: got %b exp %b", g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        io_outpad = 4'b0110;
        ext_val   = 4'b1001;
        shift_cfg(8'h1E);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        shift_cfg(8'hFF);
        step(1'b0, 1'b1, 1'b0);
        while (expq.size() > 0) begin
            e = expq.pop_front();
            g = gotq.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL back_to_back: got %b exp %b", g, e);
            end
        end
    endtask

`ifdef GRID_IO_BANK_PARITY_EN
    task automatic test_parity();
        logic [7:0] bad;
        bad = 8'h1F;
        io_outpad = 4'b0110;
        ext_val   = 4'b0001;
        shift_cfg(8'h1E);
        step(1'b0, 1'b1, 1'b0);
        vectors++;
        if (cfg_err !== 1'b0 || io_inpad !== 4'b0011) begin
            miscompares++;
            $display("FAIL parity_ok: err %b inpad %b exp 0 0011", cfg_err, io_inpad);
        end
        step(1'b1, 1'b0, 1'b1);
        for (int b = 7; b >= 0; b--)
            step(1'b1, 1'b0, bad[b]);
        step(1'b0, 1'b1, 1'b0);
        vectors++;
        if (cfg_err !== 1'b1 || io_inpad !== 4'b0011) begin
            miscompares++;
            $display("FAIL parity_bad: err %b inpad %b exp 1 0011", cfg_err, io_inpad);
        end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            g = gotq.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL parity: got %b exp %b", g, e);
            end
        end
    endtask
`endif

    initial begin
        prog_reset_n = 1'b0;
        cfg_en       = 1'b0;
        cfg_load     = 1'b0;
        ccff_head    = 1'b0;
        io_outpad    = 4'b0000;
        ext_val      = 4'b0000;
        model_reset();
        #1;
        test_reset();
        test_full_load();
        test_short_load();
        test_overshift();
        test_simultaneous();
        test_back_to_back();
`ifdef GRID_IO_BANK_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
